// File: rtl/alu_pkg.sv
// Shared ALU op codes, shift-sequencer states and count helper; no logic of its own.
// SHIFT_COUNT_MASK_EN selects a 5-bit effective shift count instead of the full 8 bits.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;

    typedef enum logic [2:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_AND,
        ALUOP_OR,
        ALUOP_XOR,
        ALUOP_SHIFT_LEFT,
        ALUOP_SHIFT_RIGHT,
        ALUOP_PASS
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } seq_state_e;

    function automatic logic [CNT_W-1:0] eff_count(input logic [CNT_W-1:0] count);
`ifdef SHIFT_COUNT_MASK_EN
        return {3'b000, count[4:0]};
`else
        return count;
`endif
    endfunction

endpackage

// File: rtl/alu_shift_seq_if.sv
// Request/result bundle of the shift sequencer: start/dir/operand/count in, busy/done/result/carry out.
// No backpressure: start is only taken while busy is low, done is a single-cycle pulse.
interface alu_shift_seq_if;
    import alu_pkg::*;

    logic              start;
    logic              dir;
    logic [DATA_W-1:0] operand;
    logic [CNT_W-1:0]  count;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              carry;

    modport master (
        output start, dir, operand, count,
        input  busy, done, result, carry
    );

    modport slave (
        input  start, dir, operand, count,
        output busy, done, result, carry
    );

endinterface

// File: rtl/alu.sv
// Combinational 16-bit ALU; zero latency, no flow control.
// Shifts move one bit per operation, B[0] is the bit shifted in and co is the bit shifted out.
module alu
    import alu_pkg::*;
(
    input  alu_op_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] r,
    output logic              co
);

    always_comb begin
        r  = '0;
        co = 1'b0;
        case (op)
            ALUOP_ADD:         {co, r} = {1'b0, a} + {1'b0, b};
            ALUOP_SUB:         {co, r} = {1'b0, a} - {1'b0, b};
            ALUOP_AND:         r = a & b;
            ALUOP_OR:          r = a | b;
            ALUOP_XOR:         r = a ^ b;
            ALUOP_SHIFT_LEFT: begin
                r  = {a[DATA_W-2:0], b[0]};
                co = a[DATA_W-1];
            end
            ALUOP_SHIFT_RIGHT: begin
                r  = {b[0], a[DATA_W-1:1]};
                co = a[0];
            end
            ALUOP_PASS:        r = a;
            default: begin
                r  = '0;
                co = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-bit logical shifter driving the single-bit ALU shift once per clock; done follows N+1 edges after start (N=0: 1 edge).
// start is accepted only while idle (busy low), never queued; SHIFT_COUNT_MASK_EN masks the count to 5 bits.
module alu_shift_seq
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    alu_shift_seq_if.slave  bus
);

    seq_state_e        state_q, state_d;
    logic [DATA_W-1:0] work_q, work_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dir_q, dir_d;
    logic              sh_carry_q, sh_carry_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              carry_q, carry_d;

    alu_op_e           alu_op;
    logic [DATA_W-1:0] alu_r;
    logic              alu_co;
    logic [CNT_W-1:0]  start_cnt;

    assign alu_op    = dir_q ? ALUOP_SHIFT_RIGHT : ALUOP_SHIFT_LEFT;
    assign start_cnt = eff_count(bus.count);

    // Zero shift-in keeps both directions logical.
    alu u_alu (
        .op (alu_op),
        .a  (work_q),
        .b  ({DATA_W{1'b0}}),
        .r  (alu_r),
        .co (alu_co)
    );

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        sh_carry_d = sh_carry_q;
        done_d     = 1'b0;
        result_d   = result_q;
        carry_d    = carry_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    work_d     = bus.operand;
                    cnt_d      = start_cnt;
                    dir_d      = bus.dir;
                    sh_carry_d = 1'b0;
                    state_d    = (start_cnt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                // cnt is at least 1 here, so the decrement cannot wrap.
                work_d     = alu_r;
                sh_carry_d = alu_co;
                cnt_d      = cnt_q - 1'b1;
                if (cnt_q == 8'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d   = 1'b1;
                result_d = work_q;
                carry_d  = sh_carry_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            work_q     <= '0;
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            sh_carry_q <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            sh_carry_q <= sh_carry_d;
            done_q     <= done_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.carry  = carry_q;

endmodule

// File: doc/alu_shift_seq.md
ALU_SHIFT_SEQ -- requirements
Module: alu_shift_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a multi-bit shift; sampled only in IDLE.
REQ-005 dir  input  1  shift direction: 0 = left, 1 = right (logical).
REQ-006 operand  input  16  value to shift; captured on an accepted start.
REQ-007 count  input  8  shift count; captured on an accepted start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse; result and carry are valid in that cycle.
REQ-010 result  output  16  shifted value; held from done until the next accepted start.
REQ-011 carry  output  1  last bit shifted out; held like result.

Function
REQ-012 The block SHALL sequence the ALU's single-bit shift operations (ALUOP_SHIFT_LEFT or ALUOP_SHIFT_RIGHT, B = 0), one bit per clock.
REQ-013 The state machine SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 IDLE with start=1 SHALL load work=operand, cnt=effective count and dir, then go to SHIFT if cnt!=0, else to DONE.
REQ-015 Each SHIFT cycle SHALL do the following:
- work <= ALU R.
- carry <= work[15] for left, or work[0] for right.
- cnt <= cnt-1.
- Leave SHIFT for DONE when cnt==1.
REQ-016 DONE SHALL assert done for exactly one cycle, drive result=work, then return to IDLE.
REQ-017 Latency SHALL be as follows, with start sampled at edge 0:
- For N>0: done is high in the cycle after edge N+1.
- For N=0: done is high after edge 1, with result=operand and carry=0.
REQ-018 start SHALL be ignored while busy=1 (SHIFT and DONE), with no queuing.
REQ-019 Counts of 16 or more SHALL yield result=0x0000; carry SHALL be the bit shifted out at step N (operand[0] or operand[15] for N=16, and 0 for N>16).
REQ-020 cnt SHALL be 8 bits wide and SHALL never wrap; a count of 255 performs exactly 255 steps.
REQ-021 dir, operand and count SHALL be ignored outside the accepting IDLE cycle.

Reset
REQ-022 While reset=1, the block SHALL hold:
- state = IDLE.
- busy = 0, done = 0.
- result = 0x0000, carry = 0.
- work = 0, cnt = 0.
REQ-023 Reset asserted mid-operation SHALL abort the shift with no done pulse.
REQ-024 The first cycle after reset deassertion SHALL accept start.

Configuration
REQ-025 With SHIFT_COUNT_MASK_EN defined, the effective count SHALL be count & 0x1F (5 bits).
REQ-026 Without SHIFT_COUNT_MASK_EN, the effective count SHALL be the full 8-bit count.

Structure
REQ-027 The ALU op enumeration (ALUOP_*) SHALL live in a shared package, alu_pkg, imported by both alu and alu_shift_seq.
REQ-028 The state enumeration (IDLE/SHIFT/DONE) SHALL be declared in alu_pkg as a typedef.
REQ-029 alu_shift_seq SHALL instantiate exactly one alu sub-module as its datapath.
REQ-030 alu_shift_seq SHALL NOT contain its own shifter logic.

Verification
REQ-031 Single left shift: operand=0x8001, dir=0, count=1 -> done at edge 2, result=0x0002, carry=1.
REQ-032 Right shift by 4: operand=0x00F0, dir=1, count=4 -> done at edge 5, result=0x000F, carry=0, busy high through edges 1-5.
REQ-033 Zero count: operand=0x1234, count=0 -> done at edge 1, result=0x1234, carry=0.
REQ-034 Masking, with operand=0xFFFF, dir=0, count=0x21:
- SHIFT_COUNT_MASK_EN defined: done at edge 2, result=0xFFFE, carry=1.
- SHIFT_COUNT_MASK_EN undefined: done at edge 34, result=0x0000, carry=0.
REQ-035 Overlap and reset:
- A second start with count=3 during a running shift SHALL change nothing.
- Reset asserted at edge 2 of a count=8 shift SHALL zero all outputs with no done pulse.
- A following start with operand=0x0001, dir=0, count=2 SHALL give result=0x0004.
